pipelined_fetch_stage: RTL and testbench
========================================

// Module: pipelined_fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS PipelinedProc; sits upstream of decode and feeds the IF/ID register.
//  Holds the PC and loads startPC after reset. Drives the instruction-memory address.
//  Applies stall, ID-stage redirects (j/jal) and EX-stage redirects (beq/bne/jr), then captures IF/ID.
// PARAMETERS
//  ADDR_W    32     PC / instruction address width
//  PC_INC    4      sequential PC increment (bytes)
//  NOP_INSTR 32'h0  instruction word inserted as a bubble (sll $0,$0,0)
// PORTS
//  CLK           in   1   clock, all state updates on posedge
//  Reset_L       in   1   reset, asynchronous, active-low
//  startPC       in   32  first fetch address; sampled on first posedge after Reset_L rises
//  stall         in   1   hazard unit: hold PC and IF/ID
//  idRedirect    in   1   ID-stage jump taken (j/jal)
//  idTarget      in   32  ID-stage jump target
//  exRedirect    in   1   EX-stage branch taken or jr
//  exTarget      in   32  EX-stage target (branch target or rs for jr)
//  imemAddr      out  32  instruction memory address (= PC), combinational
//  imemData      in   32  instruction word for imemAddr, combinational read
//  pc            out  32  current PC
//  ifid_instr    out  32  IF/ID instruction
//  ifid_pcPlus4  out  32  IF/ID PC+4 (jal link value, branch base)
//  ifid_valid    out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (Reset_L=0, async): state=LOAD, pc=0, ifid_instr=NOP_INSTR, ifid_pcPlus4=0, ifid_valid=0.
//  FSM: LOAD -> RUN on first posedge with Reset_L=1; pc<=startPC; IF/ID stays bubble; inputs ignored.
//   RUN -> RUN until reset; a reset mid-run returns immediately to LOAD, discarding all state.
//  RUN next-PC priority (highest first), evaluated each posedge:
//   1 exRedirect: pc<=exTarget; IF/ID<=bubble (ifid_valid=0, instr=NOP_INSTR, pcPlus4 unchanged)
//   2 idRedirect: pc<=idTarget; IF/ID<=bubble (no delay slot)
//   3 stall:      pc and IF/ID hold
//   4 else:       pc<=pc+PC_INC; ifid_instr<=imemData; ifid_pcPlus4<=pc+PC_INC; ifid_valid<=1
//  Redirect overrides a simultaneous stall. exRedirect wins over a simultaneous idRedirect (older instr).
//  Targets have bits[1:0] forced to 0 before loading pc. pc+PC_INC wraps modulo 2^ADDR_W.
//  Latency: word at address A appears on ifid_instr one posedge after pc==A (absent stall/redirect).
//  First valid IF/ID: the 2nd posedge after Reset_L deasserts.
//  imemAddr is pc in both states (pc is 0 in LOAD).
// STRUCTURE
//  Shared package mips_pkg: NOP_INSTR, PC_INC, fetch FSM state encoding (LOAD, RUN).
//  One sub-module: next_pc_sel (combinational priority mux + alignment + increment).
//  PC register, FSM and IF/ID register live in this module.
// TESTING
//  1 startPC=0x60, release reset, no stall -> pc 0x60,0x64,0x68 on successive edges.
//    ifid_valid=1 from edge 2, with ifid_pcPlus4=0x64.
//  2 stall=1 for 3 cycles at pc=0x68 -> pc and ifid_* unchanged for 3 edges, then resume at 0x6C.
//  3 idRedirect=1, idTarget=0x180 at pc=0x70 -> pc=0x180 next edge; ifid_valid=0, ifid_instr=0.
//  4 exRedirect (0x19C) and idRedirect (0x200) both asserted with stall=1 -> pc=0x19C, bubble in IF/ID.
//  5 exTarget=0x1A3 -> pc=0x1A0. Separately, pc=0xFFFFFFFC with no redirect -> pc=0x0 and ifid_pcPlus4=0x0.
//  6 Reset_L pulsed low mid-cycle in RUN -> outputs go to reset values without a clock edge.
//    Next run starts at the new startPC=0xA0.

Source files
------------

// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared fetch-stage constants and FSM / next-PC select encodings
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

   localparam int          c_PC_INC    = 4;
   localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_t;

   typedef enum logic [1:0] {
      SEL_SEQ  = 2'd0,
      SEL_HOLD = 2'd1,
      SEL_ID   = 2'd2,
      SEL_EX   = 2'd3
   } next_pc_src_t;

endpackage

`default_nettype wire

// File: rtl/pipelined_fetch_stage_next_pc_sel.sv
//------------------------------------------------------------------------------
// next_pc_sel : next-PC priority mux (EX > ID > stall > sequential) with alignment
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module next_pc_sel
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int PC_INC = c_PC_INC
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_stall,
   input  logic              i_id_redirect,
   input  logic [ADDR_W-1:0] i_id_target,
   input  logic              i_ex_redirect,
   input  logic [ADDR_W-1:0] i_ex_target,
   output logic [ADDR_W-1:0] o_next_pc,
   output logic [ADDR_W-1:0] o_pc_plus_inc,
   output next_pc_src_t      o_src
);

   logic [ADDR_W-1:0] w_align_mask;
   logic [ADDR_W-1:0] w_pc_plus_inc;

   assign w_align_mask  = {{(ADDR_W-2){1'b1}}, 2'b00};
   // Natural wrap modulo 2^ADDR_W from the truncated sum.
   assign w_pc_plus_inc = i_pc + ADDR_W'(PC_INC);
   assign o_pc_plus_inc = w_pc_plus_inc;

   always_comb begin
      o_src     = SEL_SEQ;
      o_next_pc = w_pc_plus_inc;
      if (i_ex_redirect) begin
         o_src     = SEL_EX;
         o_next_pc = i_ex_target & w_align_mask;
      end else if (i_id_redirect) begin
         o_src     = SEL_ID;
         o_next_pc = i_id_target & w_align_mask;
      end else if (i_stall) begin
         o_src     = SEL_HOLD;
         o_next_pc = i_pc;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipelined_fetch_stage.sv
//------------------------------------------------------------------------------
// pipelined_fetch_stage : MIPS IF stage - PC register, load/run FSM, IF/ID register
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_fetch_stage
   import mips_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter int          PC_INC    = c_PC_INC,
   parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic [ADDR_W-1:0] startPC,
   input  logic              stall,
   input  logic              idRedirect,
   input  logic [ADDR_W-1:0] idTarget,
   input  logic              exRedirect,
   input  logic [ADDR_W-1:0] exTarget,
   output logic [ADDR_W-1:0] imemAddr,
   input  logic [31:0]       imemData,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pcPlus4,
   output logic              ifid_valid
);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_ifid_instr;
   logic [ADDR_W-1:0] r_ifid_pc_plus4;
   logic              r_ifid_valid;

   logic [ADDR_W-1:0] w_next_pc;
   logic [ADDR_W-1:0] w_pc_plus_inc;
   next_pc_src_t      w_src;

   next_pc_sel #(
      .ADDR_W (ADDR_W),
      .PC_INC (PC_INC)
   ) u_next_pc_sel (
      .i_pc          (r_pc),
      .i_stall       (stall),
      .i_id_redirect (idRedirect),
      .i_id_target   (idTarget),
      .i_ex_redirect (exRedirect),
      .i_ex_target   (exTarget),
      .o_next_pc     (w_next_pc),
      .o_pc_plus_inc (w_pc_plus_inc),
      .o_src         (w_src)
   );

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state         <= ST_LOAD;
         r_pc            <= '0;
         r_ifid_instr    <= NOP_INSTR;
         r_ifid_pc_plus4 <= '0;
         r_ifid_valid    <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_state <= ST_RUN;
               r_pc    <= startPC;
            end
            ST_RUN: begin
               r_pc <= w_next_pc;
               case (w_src)
                  SEL_EX, SEL_ID: begin
                     // Squash the wrong-path fetch; pcPlus4 is left as-is.
                     r_ifid_instr <= NOP_INSTR;
                     r_ifid_valid <= 1'b0;
                  end
                  SEL_SEQ: begin
                     r_ifid_instr    <= imemData;
                     r_ifid_pc_plus4 <= w_pc_plus_inc;
                     r_ifid_valid    <= 1'b1;
                  end
                  default: ;
               endcase
            end
            default: r_state <= ST_LOAD;
         endcase
      end
   end

   assign imemAddr     = r_pc;
   assign pc           = r_pc;
   assign ifid_instr   = r_ifid_instr;
   assign ifid_pcPlus4 = r_ifid_pc_plus4;
   assign ifid_valid   = r_ifid_valid;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_pipelined_fetch_stage : directed vector table plus reset corner sequences
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_fetch_stage;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic [31:0] startPC;
   logic        stall;
   logic        idRedirect;
   logic [31:0] idTarget;
   logic        exRedirect;
   logic [31:0] exTarget;
   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pcPlus4;
   logic        ifid_valid;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imemData = mem(imemAddr);

   pipelined_fetch_stage dut (
      .CLK          (CLK),
      .Reset_L      (Reset_L),
      .startPC      (startPC),
      .stall        (stall),
      .idRedirect   (idRedirect),
      .idTarget     (idTarget),
      .exRedirect   (exRedirect),
      .exTarget     (exTarget),
      .imemAddr     (imemAddr),
      .imemData     (imemData),
      .pc           (pc),
      .ifid_instr   (ifid_instr),
      .ifid_pcPlus4 (ifid_pcPlus4),
      .ifid_valid   (ifid_valid)
   );

   typedef struct {
      logic        st;
      logic        idr;
      logic [31:0] idt;
      logic        exr;
      logic [31:0] ext;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_pp4;
      logic        e_valid;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic [31:0] e_pp4, input logic e_valid);
      chk({tag, " pc"},       pc,           e_pc);
      chk({tag, " imemAddr"}, imemAddr,     e_pc);
      chk({tag, " instr"},    ifid_instr,   e_instr);
      chk({tag, " pcPlus4"},  ifid_pcPlus4, e_pp4);
      chk({tag, " valid"},    {31'd0, ifid_valid}, {31'd0, e_valid});
   endtask

   function automatic vec_t mk(input logic st, input logic idr, input logic [31:0] idt,
                               input logic exr, input logic [31:0] ext, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic [31:0] e_pp4,
                               input logic e_valid);
      vec_t v;
      v.st = st; v.idr = idr; v.idt = idt; v.exr = exr; v.ext = ext;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_pp4 = e_pp4; v.e_valid = e_valid;
      return v;
   endfunction

   task automatic idle_inputs();
      stall = 1'b0; idRedirect = 1'b0; idTarget = '0; exRedirect = 1'b0; exTarget = '0;
   endtask

   initial begin
      Reset_L = 1'b0;
      startPC = 32'h60;
      idle_inputs();

      // stall, idR, idT, exR, exT -> pc, instr, pcPlus4, valid (each row = one posedge)
      vq.push_back(mk(0,0,0,0,0,            32'h64,       mem(32'h60),       32'h64,       1));
      vq.push_back(mk(0,0,0,0,0,            32'h68,       mem(32'h64),       32'h68,       1));
      vq.push_back(mk(1,0,0,0,0,            32'h68,       mem(32'h64),       32'h68,       1));
      vq.push_back(mk(1,0,0,0,0,            32'h68,       mem(32'h64),       32'h68,       1));
      vq.push_back(mk(1,0,0,0,0,            32'h68,       mem(32'h64),       32'h68,       1));
      vq.push_back(mk(0,0,0,0,0,            32'h6C,       mem(32'h68),       32'h6C,       1));
      vq.push_back(mk(0,0,0,0,0,            32'h70,       mem(32'h6C),       32'h70,       1));
      vq.push_back(mk(0,1,32'h180,0,0,      32'h180,      32'h0,             32'h70,       0));
      vq.push_back(mk(0,0,0,0,0,            32'h184,      mem(32'h180),      32'h184,      1));
      vq.push_back(mk(1,1,32'h200,1,32'h19C,32'h19C,      32'h0,             32'h184,      0));
      vq.push_back(mk(0,0,0,1,32'h1A3,      32'h1A0,      32'h0,             32'h184,      0));
      vq.push_back(mk(0,1,32'h203,0,0,      32'h200,      32'h0,             32'h184,      0));
      vq.push_back(mk(0,0,0,0,0,            32'h204,      mem(32'h200),      32'h204,      1));
      vq.push_back(mk(0,0,0,1,32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,             32'h204,      0));
      vq.push_back(mk(0,0,0,0,0,            32'h0,        mem(32'hFFFFFFFC), 32'h0,        1));
      vq.push_back(mk(0,0,0,0,0,            32'h4,        mem(32'h0),        32'h4,        1));
      vq.push_back(mk(1,1,32'h300,0,0,      32'h300,      32'h0,             32'h4,        0));
      vq.push_back(mk(1,0,0,0,0,            32'h300,      32'h0,             32'h4,        0));

      #2;
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      @(posedge CLK); #1;
      chk_all("reset held", 32'h0, 32'h0, 32'h0, 1'b0);

      Reset_L = 1'b1;
      @(posedge CLK); #1;
      chk_all("load", 32'h60, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         stall      = vq[i].st;
         idRedirect = vq[i].idr;
         idTarget   = vq[i].idt;
         exRedirect = vq[i].exr;
         exTarget   = vq[i].ext;
         @(posedge CLK); #1;
         chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_instr, vq[i].e_pp4, vq[i].e_valid);
      end
      idle_inputs();

      // Asynchronous reset in the middle of a cycle, no clock edge involved.
      @(posedge CLK); #3;
      Reset_L = 1'b0;
      #1;
      chk_all("async reset", 32'h0, 32'h0, 32'h0, 1'b0);

      startPC = 32'hA0;
      @(posedge CLK); #1;
      Reset_L = 1'b1;
      // Redirect during LOAD must be ignored.
      exRedirect = 1'b1; exTarget = 32'h500; stall = 1'b1;
      @(posedge CLK); #1;
      chk_all("reload", 32'hA0, 32'h0, 32'h0, 1'b0);
      idle_inputs();
      @(posedge CLK); #1;
      chk_all("restart", 32'hA4, mem(32'hA0), 32'hA4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
